acia_tx_shifter: RTL and testbench

//  6551-compatible ACIA transmitter. Takes the 16x baud clock BCLK from the baud-rate generator and a byte from the CPU.

---
 rtl/acia_tx_shifter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_acia_tx_shifter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_tx_shifter.sv
// acia_tx_shifter: 6551-compatible ACIA transmitter.
// Serialises the TDR byte onto TXD: start bit, 5-8 data bits LSB first,
// an optional parity bit, then 1, 1.5 or 2 stop bits. Bit timing comes from
// the 16x baud clock BCLK, which is synchronised into the CLK domain.
// Optional feature macro: ACIA_TX_CTS_EN (CTSB gates new transfers).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line idle (mark), or space while TX_BRK is held
// S_START | start bit (space) for OVS ticks
// S_DATA  | data bits LSB first, OVS ticks each
// S_PARITY| parity / mark / space bit for OVS ticks
// S_STOP  | stop time (mark), 1, 1.5 or 2 bit times
module acia_tx_shifter #(
    parameter int OVS   = 16,
    parameter int CNT_W = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BCLK,
    input  logic       TDR_WR,
    input  logic [7:0] TDR_DIN,
    input  logic [1:0] R_WL,
    input  logic       R_SBN,
    input  logic       R_PME,
    input  logic [1:0] R_PMC,
    input  logic       TX_EN,
    input  logic       TX_BRK,
    input  logic       CTSB,
    output logic       TXD,
    output logic       TDRE,
    output logic       TX_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);

    logic             rst_meta;
    logic             rst_n_int;
    logic             bclk_s1;
    logic             bclk_s2;
    logic             bclk_s3;
    logic             tick;

    logic [7:0]       tdr;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nxt;
    state_t           state;
    state_t           state_nxt;

    logic [1:0]       wl_l;
    logic             sbn_l;
    logic             pme_l;
    logic             par_l;

    logic             cts_ok;
    logic             can_xfer;
    logic             xfer;
    logic [2:0]       last_bit;
    logic             stop_ext;
    logic             stop_half;
    logic [7:0]       tdr_masked;
    logic             par_calc;

`ifdef ACIA_TX_CTS_EN
    assign cts_ok = ~CTSB;
`else
    // CTSB has no influence on transmission in this build.
    assign cts_ok = CTSB | 1'b1;
`endif

    assign can_xfer = ~TDRE & TX_EN & ~TX_BRK & cts_ok;
    assign tick     = bclk_s2 & ~bclk_s3;
    assign last_bit = 3'd7 - {1'b0, wl_l};

    // Second stop period exists for SBN=1 unless 8 bits with parity;
    // it is only half a bit for 5 bits without parity.
    assign stop_ext  = sbn_l & ~((wl_l == 2'b00) & pme_l);
    assign stop_half = (wl_l == 2'b11) & ~pme_l;

    assign tdr_masked = tdr & (8'hFF >> R_WL);

    // Parity bit chosen from the data being loaded and the live config.
    always_comb begin
        case (R_PMC)
            2'b00:   par_calc = ~(^tdr_masked);
            2'b01:   par_calc = ^tdr_masked;
            2'b10:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    // Reset: asserted asynchronously, released two CLK edges later.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    // BCLK synchroniser plus one stage for rising-edge detect.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
        end else begin
            bclk_s1 <= BCLK;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
        end
    end

    // Transmit data register; a CPU write beats a coincident transfer.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tdr  <= 8'h00;
            TDRE <= 1'b1;
        end else if (TDR_WR) begin
            tdr  <= TDR_DIN;
            TDRE <= 1'b0;
        end else if (xfer) begin
            TDRE <= 1'b1;
        end
    end

    // State, counters and shift register.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Character format latched at transfer so config changes wait.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wl_l  <= 2'b00;
            sbn_l <= 1'b0;
            pme_l <= 1'b0;
            par_l <= 1'b0;
        end else if (xfer) begin
            wl_l  <= R_WL;
            sbn_l <= R_SBN;
            pme_l <= R_PME;
            par_l <= par_calc;
        end
    end

    // Next-state logic; everything advances only on a BCLK tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        xfer      = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (can_xfer) xfer = 1'b1;
                end
                S_START: begin
                    if (cnt == '0) begin
                        state_nxt = S_DATA;
                        cnt_nxt   = BIT_LAST;
                        bit_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        cnt_nxt = BIT_LAST;
                        if (bit_cnt == last_bit) begin
                            state_nxt = pme_l ? S_PARITY : S_STOP;
                            bit_nxt   = 3'd0;
                        end else begin
                            bit_nxt   = bit_cnt + 3'd1;
                            shreg_nxt = {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == '0) begin
                        state_nxt = S_STOP;
                        cnt_nxt   = BIT_LAST;
                        bit_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if ((bit_cnt == 3'd0) && stop_ext) begin
                            bit_nxt = 3'd1;
                            cnt_nxt = stop_half ? HALF_LAST : BIT_LAST;
                        end else if (can_xfer) begin
                            xfer = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                            bit_nxt   = 3'd0;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    bit_nxt   = 3'd0;
                end
            endcase
            if (xfer) begin
                state_nxt = S_START;
                cnt_nxt   = BIT_LAST;
                bit_nxt   = 3'd0;
                shreg_nxt = tdr;
            end
        end
    end

    // Line level decoded from state; break forces space only while idle.
    always_comb begin
        TXD = 1'b1;
        case (state)
            S_IDLE:   TXD = ~TX_BRK;
            S_START:  TXD = 1'b0;
            S_DATA:   TXD = shreg[0];
            S_PARITY: TXD = par_l;
            default:  TXD = 1'b1;
        endcase
    end

    assign TX_BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_acia_tx_shifter.sv
// tb_acia_tx_shifter: table-driven, randomised and hand-sequenced checks
// of the ACIA transmitter against a frame-level reference model.
module tb_acia_tx_shifter;

    localparam int OVS = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BCLK = 1'b0;
    logic       TDR_WR = 1'b0;
    logic [7:0] TDR_DIN = 8'h00;
    logic [1:0] R_WL = 2'b00;
    logic       R_SBN = 1'b0;
    logic       R_PME = 1'b0;
    logic [1:0] R_PMC = 2'b00;
    logic       TX_EN = 1'b1;
    logic       TX_BRK = 1'b0;
    logic       CTSB = 1'b0;
    logic       TXD;
    logic       TDRE;
    logic       TX_BUSY;

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] wl;
        logic       sbn;
        logic       pme;
        logic [1:0] pmc;
        int         busy;
    } vec_t;

    vec_t vt[7];

    acia_tx_shifter #(.OVS(OVS), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .BCLK(BCLK),
        .TDR_WR(TDR_WR), .TDR_DIN(TDR_DIN),
        .R_WL(R_WL), .R_SBN(R_SBN), .R_PME(R_PME), .R_PMC(R_PMC),
        .TX_EN(TX_EN), .TX_BRK(TX_BRK), .CTSB(CTSB),
        .TXD(TXD), .TDRE(TDRE), .TX_BUSY(TX_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One BCLK period of 6 CLKs; the DUT has acted on the tick on return.
    task automatic do_tick();
        @(negedge CLK) BCLK = 1'b1;
        repeat (3) @(negedge CLK);
        BCLK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic write_tdr(input logic [7:0] b);
        @(negedge CLK);
        TDR_WR = 1'b1;
        TDR_DIN = b;
        @(negedge CLK);
        TDR_WR = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] wl, input logic sbn, input logic pme, input logic [1:0] pmc);
        R_WL = wl;
        R_SBN = sbn;
        R_PME = pme;
        R_PMC = pmc;
    endtask

    // Reference: expected TXD after each tick of one character, appended.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] wl, input logic sbn,
                               input logic pme, input logic [1:0] pmc);
        int n;
        int ones;
        int stop;
        logic p;
        n = 8 - int'(wl);
        ones = 0;
        repeat (OVS) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (OVS) exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pme) begin
            case (pmc)
                2'b00: p = ((ones % 2) == 0);
                2'b01: p = ((ones % 2) == 1);
                2'b10: p = 1'b1;
                default: p = 1'b0;
            endcase
            repeat (OVS) exp_q.push_back(p);
        end
        if (!sbn) stop = OVS;
        else if (n == 8 && pme) stop = OVS;
        else if (n == 5 && !pme) stop = OVS * 3 / 2;
        else stop = 2 * OVS;
        repeat (stop) exp_q.push_back(1'b1);
    endtask

    // Tick until TX_BUSY drops, comparing TXD against exp_q.
    // kind: 0 none, 1 scramble config, 2 drop TX_EN + write 77,
    //       3 raise TX_BRK + write 22, 4 write 3C (back-to-back).
    task automatic run_frame(input string nm, input int kind, input int hook_at, output int busy);
        busy = 0;
        for (int t = 0; t < 700; t++) begin
            if (t == hook_at) begin
                case (kind)
                    1: set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
                    2: begin TX_EN = 1'b0; write_tdr(8'h77); end
                    3: begin TX_BRK = 1'b1; write_tdr(8'h22); end
                    4: write_tdr(8'h3C);
                    default: ;
                endcase
            end
            do_tick();
            if (!TX_BUSY) break;
            busy++;
            if (t == 0) check({nm, " tdre_on_start"}, TDRE, 1);
            if (kind == 4 && t == 159) check({nm, " tdre_pending"}, TDRE, 0);
            if (kind == 4 && t == 160) check({nm, " tdre_second"}, TDRE, 1);
            if (t < exp_q.size()) check($sformatf("%s txd[%0d]", nm, t), TXD, exp_q[t]);
        end
    endtask

    int busy;
    int bad;

    initial begin
        vt[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 2'b00, 160};
        vt[1] = '{8'hC1, 2'b01, 1'b0, 1'b1, 2'b01, 160};
        vt[2] = '{8'h1F, 2'b11, 1'b1, 1'b0, 2'b00, 120};
        vt[3] = '{8'hA5, 2'b00, 1'b1, 1'b0, 2'b00, 176};
        vt[4] = '{8'hA5, 2'b00, 1'b1, 1'b1, 2'b00, 176};
        vt[5] = '{8'h3C, 2'b10, 1'b1, 1'b1, 2'b10, 160};
        vt[6] = '{8'h07, 2'b11, 1'b1, 1'b1, 2'b11, 144};

        repeat (3) @(negedge CLK);
        check("reset_txd", TXD, 1);
        check("reset_tdre", TDRE, 1);
        check("reset_busy", TX_BUSY, 0);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_reset_txd", TXD, 1);
        check("post_reset_tdre", TDRE, 1);

        // Directed formats.
        for (int i = 0; i < 7; i++) begin
            set_cfg(vt[i].wl, vt[i].sbn, vt[i].pme, vt[i].pmc);
            write_tdr(vt[i].data);
            check($sformatf("vec%0d tdre_after_wr", i), TDRE, 0);
            exp_q.delete();
            build_frame(vt[i].data, vt[i].wl, vt[i].sbn, vt[i].pme, vt[i].pmc);
            run_frame($sformatf("vec%0d", i), 0, -1, busy);
            check($sformatf("vec%0d busy_ticks", i), busy, vt[i].busy);
            check($sformatf("vec%0d idle_txd", i), TXD, 1);
        end

        // Random bytes/formats; config scrambled after the transfer.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic [1:0] wl;
            logic sbn;
            logic pme;
            logic [1:0] pmc;
            d = 8'($urandom);
            wl = 2'($urandom_range(0, 3));
            sbn = 1'($urandom);
            pme = 1'($urandom);
            pmc = 2'($urandom_range(0, 3));
            set_cfg(wl, sbn, pme, pmc);
            write_tdr(d);
            exp_q.delete();
            build_frame(d, wl, sbn, pme, pmc);
            run_frame($sformatf("rnd%0d", i), 1, 1, busy);
            check($sformatf("rnd%0d busy_ticks", i), busy, exp_q.size());
        end

        // Back-to-back: second byte written during the first start bit.
        set_cfg(2'b00, 1'b0, 1'b0, 2'b00);
        write_tdr(8'hA5);
        exp_q.delete();
        build_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b00);
        build_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("b2b", 4, 3, busy);
        check("b2b busy_ticks", busy, 320);

        // TX_EN dropped mid-character: completes, pending byte held.
        write_tdr(8'h5A);
        exp_q.delete();
        build_frame(8'h5A, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("txen", 2, 40, busy);
        check("txen busy_ticks", busy, 160);
        check("txen tdre_held", TDRE, 0);
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            do_tick();
            if (TX_BUSY !== 1'b0 || TXD !== 1'b1) bad++;
        end
        check("txen no_transfer", bad, 0);
        TX_EN = 1'b1;
        exp_q.delete();
        build_frame(8'h77, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("txen_resume", 0, -1, busy);
        check("txen_resume busy_ticks", busy, 160);

        // Break raised mid-character with a byte pending.
        write_tdr(8'h11);
        exp_q.delete();
        build_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("brk", 3, 50, busy);
        check("brk busy_ticks", busy, 160);
        check("brk txd_space", TXD, 0);
        check("brk tdre_held", TDRE, 0);
        bad = 0;
        for (int t = 0; t < 12; t++) begin
            do_tick();
            if (TX_BUSY !== 1'b0 || TXD !== 1'b0 || TDRE !== 1'b0) bad++;
        end
        check("brk held", bad, 0);
        @(negedge CLK) TX_BRK = 1'b0;
        exp_q.delete();
        build_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("brk_release", 0, -1, busy);
        check("brk_release busy_ticks", busy, 160);

        // Reset during DATA with a byte pending.
        write_tdr(8'h0F);
        for (int t = 0; t < 40; t++) do_tick();
        write_tdr(8'hF0);
        check("rst_mid busy_before", TX_BUSY, 1);
        @(negedge CLK) RESET = 1'b0;
        #1;
        check("rst_mid txd", TXD, 1);
        check("rst_mid tdre", TDRE, 1);
        check("rst_mid busy", TX_BUSY, 0);
        @(negedge CLK) RESET = 1'b1;
        repeat (4) @(negedge CLK);
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            do_tick();
            if (TX_BUSY !== 1'b0 || TXD !== 1'b1 || TDRE !== 1'b1) bad++;
        end
        check("rst_mid discarded", bad, 0);

        // CTSB gating.
`ifdef ACIA_TX_CTS_EN
        CTSB = 1'b1;
        write_tdr(8'h80);
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            do_tick();
            if (TXD !== 1'b1 || TDRE !== 1'b0 || TX_BUSY !== 1'b0) bad++;
        end
        check("cts blocked", bad, 0);
        @(negedge CLK) CTSB = 1'b0;
        exp_q.delete();
        build_frame(8'h80, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("cts_release", 0, -1, busy);
        check("cts_release busy_ticks", busy, 160);
`else
        CTSB = 1'b1;
        write_tdr(8'h80);
        exp_q.delete();
        build_frame(8'h80, 2'b00, 1'b0, 1'b0, 2'b00);
        run_frame("cts_ignored", 0, -1, busy);
        check("cts_ignored busy_ticks", busy, 160);
        CTSB = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
